q_update_scheduler: RTL and testbench
=====================================

Name: q_update_scheduler

Overview:
Sequences the Q-table memory-interface datapath for one learning episode. It accepts state/action steps from the agent through a valid/ready handshake and drives the registered S/A issue into the memory interface. It times the write-enable so each write lands exactly WR_LAT cycles after its read issue. It stalls any step whose state is still in flight (read-after-write hazard), counts steps, and drains the pipeline before signalling episode completion.

Parameters:
L_WIDTH, 4, action/level width; state width = 2*L_WIDTH, action width = L_WIDTH/2+2
WR_LAT, 5, cycles from issue cycle to write cycle (memory-interface S pipeline depth)
CNT_WIDTH, 16, step/episode counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin episode (honoured only in IDLE)
stop  in  1  pulse: end episode early (RUN only)
max_steps  in  CNT_WIDTH  step limit, latched on start
step_valid  in  1  agent presents step
step_ready  out  1  scheduler accepts step this cycle
step_S  in  2*L_WIDTH  current state
step_A  in  L_WIDTH/2+2  chosen action
S_out  out  2*L_WIDTH  state to memory interface (drives read address)
A_out  out  L_WIDTH/2+2  action to memory interface
issue  out  1  S_out/A_out hold a new step this cycle
wen  out  1  write enable to memory interface
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at episode end
step_cnt  out  CNT_WIDTH  steps accepted this episode
ep_cnt  out  CNT_WIDTH  completed episodes (wraps at 2^CNT_WIDTH)

Behaviour:
- Reset: FSM=IDLE; S_out=0, A_out=0, issue=0, wen=0, busy=0, done=0, step_ready=0, step_cnt=0, ep_cnt=0, all in-flight tags invalid. Reset mid-episode discards pending writes; no wen follows.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start: latch max_steps, clear step_cnt. If the latched max_steps=0, go IDLE -> DRAIN directly.
- RUN -> DRAIN when an accept brings step_cnt to max_steps, or on stop. If stop coincides with a handshake, the step is accepted first.
- DRAIN -> DONE when no in-flight tag is valid and issue=0.
- DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE; ep_cnt increments on DONE entry.
- start outside IDLE is ignored.
- Accept = step_valid & step_ready. step_ready = (FSM==RUN) & (step_cnt<max_steps) & !hazard.
- On accept at edge e: S_out/A_out load step_S/step_A, and issue=1 during the following cycle (the issue cycle). Otherwise issue=0 and S_out/A_out hold.
- In-flight tracking: tag pipe of WR_LAT entries {v, S}. Each cycle pipe[0] <= {issue, S_out}, and pipe[k] <= pipe[k-1].
- wen = pipe[WR_LAT-1].v. With issue in cycle c, wen=1 in cycle c+WR_LAT.
- hazard = step_S equals S_out while issue=1, or equals any valid pipe[0..WR_LAT-2].S. pipe[WR_LAT-1] is excluded because its write completes before the next issue reads.
- Throughput is 1 step/cycle with no hazards.
- step_cnt increments on each accept and saturates at max_steps.
- Counter widths are unsigned; the step_cnt<max_steps comparison is unsigned.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3); state width and action width derived from L_WIDTH; default WR_LAT.
- One sub-module: inflight_tag_pipe. It implements the WR_LAT-deep {v,S} shift register, exposes the hazard compare against a probe state, and provides the tail valid used as wen.

Test Plan:
- Reset mid-episode: wen due next cycle, assert rst -> wen stays 0, busy=0, all counters 0.
- start, max_steps=3, steps S=1,2,3 back-to-back from cycle 0 -> issue in cycles 1,2,3; wen in cycles 6,7,8; done pulses in cycle 9; ep_cnt=1.
- Hazard: S=5 accepted at cycle 0, then S=5 held valid -> step_ready=0 in cycles 1-5; accept at cycle 6; wen at cycles 6 and 12.
- stop in RUN with step_valid=1 and no hazard -> that step is accepted; step_ready=0 afterwards; done follows the last wen by 1 cycle.
- max_steps=0 with start -> no issue, no wen; done pulses 2 cycles after start.
- start asserted during RUN/DRAIN -> ignored; max_steps re-latched only on the next IDLE start.

Source files
------------

// File: rtl/q_update_scheduler_pkg.sv
// Shared types and sizing helpers for the Q-table update scheduler.
package q_update_scheduler_pkg;

  localparam int L_WIDTH_DEF   = 4;
  localparam int WR_LAT_DEF    = 5;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  function automatic int s_width(input int l);
    return 2 * l;
  endfunction

  function automatic int a_width(input int l);
    return l / 2 + 2;
  endfunction

endpackage

// File: rtl/q_update_scheduler_if.sv
// Agent step handshake plus the S/A issue and write-enable towards the memory interface.
interface q_update_scheduler_if
  import q_update_scheduler_pkg::*;
#(
  parameter int L_WIDTH = L_WIDTH_DEF
);
  localparam int SW = s_width(L_WIDTH);
  localparam int AW = a_width(L_WIDTH);

  logic          step_valid;
  logic          step_ready;
  logic [SW-1:0] step_S;
  logic [AW-1:0] step_A;
  logic [SW-1:0] S_out;
  logic [AW-1:0] A_out;
  logic          issue;
  logic          wen;

  modport master (
    output step_valid, step_S, step_A,
    input  step_ready, S_out, A_out, issue, wen
  );

  modport slave (
    input  step_valid, step_S, step_A,
    output step_ready, S_out, A_out, issue, wen
  );
endinterface

// File: rtl/q_update_scheduler_inflight_tag_pipe.sv
// WR_LAT-deep in-flight tag shift register: hazard compare against a probe state,
// drain status, and the tail valid that becomes the memory write enable.
module inflight_tag_pipe #(
  parameter int WR_LAT = 5,
  parameter int S_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_v,
  input  logic [S_W-1:0] in_s,
  input  logic [S_W-1:0] probe,
  output logic           hazard,
  output logic           pending,
  output logic           tail_v
);

  logic [WR_LAT-1:0]          vld_pipe;
  // The tail's state is never compared (its write lands before the next read), so it is not stored.
  logic [WR_LAT-2:0][S_W-1:0] s_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s_pipe   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[WR_LAT-2:0], in_v};
      s_pipe[0] <= in_s;
      for (int k = 1; k < WR_LAT - 1; k++) s_pipe[k] <= s_pipe[k-1];
    end
  end

  always_comb begin
    hazard = in_v && (in_s == probe);
    for (int k = 0; k < WR_LAT - 1; k++)
      if (vld_pipe[k] && (s_pipe[k] == probe)) hazard = 1'b1;
  end

  assign pending = |vld_pipe[WR_LAT-2:0];
  assign tail_v  = vld_pipe[WR_LAT-1];

endmodule

// File: rtl/q_update_scheduler.sv
// Episode sequencer: accepts agent steps, issues S/A to the memory interface,
// stalls read-after-write hazards and drains in-flight writes before signalling done.
module q_update_scheduler
  import q_update_scheduler_pkg::*;
#(
  parameter int L_WIDTH   = L_WIDTH_DEF,
  parameter int WR_LAT    = WR_LAT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] max_steps,
  q_update_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] step_cnt,
  output logic [CNT_WIDTH-1:0] ep_cnt
);

  localparam int SW = s_width(L_WIDTH);
  localparam int AW = a_width(L_WIDTH);

  sched_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] max_q;
  logic [SW-1:0]        s_q;
  logic [AW-1:0]        a_q;
  logic                 issue_q;
  logic                 hazard, pending, tail_v;
  logic                 ready, accept, last_step;

  inflight_tag_pipe #(.WR_LAT(WR_LAT), .S_W(SW)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .in_v    (issue_q),
    .in_s    (s_q),
    .probe   (bus.step_S),
    .hazard  (hazard),
    .pending (pending),
    .tail_v  (tail_v)
  );

  assign ready     = (state_q == ST_RUN) && (step_cnt < max_q) && !hazard;
  assign accept    = bus.step_valid && ready;
  assign last_step = (step_cnt + CNT_WIDTH'(1)) == max_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (max_steps == '0) ? ST_DRAIN : ST_RUN;
      // A step offered alongside stop is still taken; accept does not look at stop.
      ST_RUN:   if ((accept && last_step) || stop) state_d = ST_DRAIN;
      ST_DRAIN: if (!pending && !issue_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      max_q    <= '0;
      step_cnt <= '0;
      ep_cnt   <= '0;
      s_q      <= '0;
      a_q      <= '0;
      issue_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= accept;
      if (state_q == ST_IDLE && start) begin
        max_q    <= max_steps;
        step_cnt <= '0;
      end else if (accept) begin
        step_cnt <= step_cnt + CNT_WIDTH'(1);
      end
      if (accept) begin
        s_q <= bus.step_S;
        a_q <= bus.step_A;
      end
      if (state_d == ST_DONE && state_q != ST_DONE) ep_cnt <= ep_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.step_ready = ready;
  assign bus.S_out      = s_q;
  assign bus.A_out      = a_q;
  assign bus.issue      = issue_q;
  assign bus.wen        = tail_v;
  assign busy           = state_q != ST_IDLE;
  assign done           = state_q == ST_DONE;

endmodule

// File: tb/tb_q_update_scheduler.sv
// Directed scoreboard bench: stimulus queues expected issue/wen/done events, a negedge monitor checks them.
module tb_q_update_scheduler;
  import q_update_scheduler_pkg::*;

  localparam int LW = 4, WL = 5, CW = 16;
  localparam int SW = 2 * LW, AW = LW / 2 + 2;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [CW-1:0] max_steps = '0;
  logic          busy, done;
  logic [CW-1:0] step_cnt, ep_cnt;

  q_update_scheduler_if #(.L_WIDTH(LW)) bus ();

  q_update_scheduler #(.L_WIDTH(LW), .WR_LAT(WL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .max_steps(max_steps),
    .bus(bus.slave), .busy(busy), .done(done), .step_cnt(step_cnt), .ep_cnt(ep_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [SW-1:0] s; logic [AW-1:0] a; } iss_t;
  typedef struct { int cyc; int ep; } done_t;
  iss_t  q_iss[$];
  int    q_wen[$];
  done_t q_done[$];

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin : mon
    iss_t  ei;
    done_t ed;
    int    ew;
    if (bus.issue === 1'b1) begin
      if (q_iss.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        ei = q_iss.pop_front();
        chk("issue_cycle", cyc, ei.cyc);
        chk("issue_S", bus.S_out, ei.s);
        chk("issue_A", bus.A_out, ei.a);
      end
    end
    if (bus.wen === 1'b1) begin
      if (q_wen.size() == 0) chk("unexpected_wen", 1, 0);
      else begin
        ew = q_wen.pop_front();
        chk("wen_cycle", cyc, ew);
      end
    end
    if (done === 1'b1) begin
      if (q_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ed = q_done.pop_front();
        chk("done_cycle", cyc, ed.cyc);
        chk("done_ep_cnt", ep_cnt, ed.ep);
      end
    end
  end

  task automatic start_ep(input int m, output int s_cyc);
    s_cyc = cyc;
    start = 1'b1;
    max_steps = CW'(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int s, input int a, output int acc);
    bus.step_valid = 1'b1;
    bus.step_S = SW'(s);
    bus.step_A = AW'(a);
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.step_ready) begin acc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    chk({nm, "_idle_timeout"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int b, s, a0, a1, a2;
    bus.step_valid = 1'b0; bus.step_S = '0; bus.step_A = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_ready", bus.step_ready, 0);
    chk("rst_issue", bus.issue, 0); chk("rst_wen", bus.wen, 0);
    chk("rst_S", bus.S_out, 0);     chk("rst_A", bus.A_out, 0);
    chk("rst_step_cnt", step_cnt, 0); chk("rst_ep_cnt", ep_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Three back-to-back steps, max_steps=3
    start_ep(3, s); b = cyc;
    q_iss.push_back('{b+1, 8'd1, 4'd1}); q_iss.push_back('{b+2, 8'd2, 4'd2});
    q_iss.push_back('{b+3, 8'd3, 4'd3});
    q_wen.push_back(b+6); q_wen.push_back(b+7); q_wen.push_back(b+8);
    q_done.push_back('{b+9, 1});
    send(1, 1, a0); send(2, 2, a1); send(3, 3, a2);
    chk("t1_acc0", a0, b); chk("t1_acc1", a1, b+1); chk("t1_acc2", a2, b+2);
    wait_idle("t1");
    chk("t1_step_cnt", step_cnt, 3); chk("t1_ep_cnt", ep_cnt, 1);

    // Hazard on S=5; start during RUN must not re-latch max_steps
    start_ep(2, s); b = cyc;
    q_iss.push_back('{b+1, 8'd5, 4'd1}); q_iss.push_back('{b+7, 8'd5, 4'd2});
    q_wen.push_back(b+6); q_wen.push_back(b+12);
    q_done.push_back('{b+13, 2});
    bus.step_valid = 1'b1; bus.step_S = 8'd5; bus.step_A = 4'd1;
    @(negedge clk); chk("t2_ready_first", bus.step_ready, 1);
    @(posedge clk); #1 bus.step_A = 4'd2;
    for (int i = 1; i <= 5; i++) begin
      start = (i == 2); max_steps = 16'd1;
      @(negedge clk); chk("t2_ready_hazard", bus.step_ready, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk); chk("t2_ready_clear", bus.step_ready, 1);
    @(posedge clk); #1 bus.step_valid = 1'b0;
    wait_idle("t2");
    chk("t2_step_cnt", step_cnt, 2);

    // stop coincident with a handshake; start during DRAIN ignored
    start_ep(10, s); b = cyc;
    q_iss.push_back('{b+1, 8'd7, 4'd3});
    q_wen.push_back(b+6);
    q_done.push_back('{b+7, 3});
    bus.step_valid = 1'b1; bus.step_S = 8'd7; bus.step_A = 4'd3; stop = 1'b1;
    @(negedge clk); chk("t3_ready_stop", bus.step_ready, 1);
    @(posedge clk); #1 stop = 1'b0; bus.step_S = 8'd8; bus.step_A = 4'd0;
    @(negedge clk); chk("t3_ready_after", bus.step_ready, 0); chk("t3_step_cnt", step_cnt, 1);
    @(posedge clk); #1 start = 1'b1; max_steps = '0;
    @(posedge clk); #1 start = 1'b0; bus.step_valid = 1'b0;
    wait_idle("t3");
    chk("t3_step_cnt_end", step_cnt, 1);

    // max_steps=0: straight to drain, done two cycles after start
    start_ep(0, s);
    q_done.push_back('{s+2, 4});
    wait_idle("t4");
    chk("t4_step_cnt", step_cnt, 0); chk("t4_ep_cnt", ep_cnt, 4);

    // Reset one cycle before a write is due
    start_ep(1, s); b = cyc;
    q_iss.push_back('{b+1, 8'd9, 4'd1});
    send(9, 1, a0);
    chk("t5_acc", a0, b);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_wen", bus.wen, 0); chk("t5_busy", busy, 0);
    chk("t5_step_cnt", step_cnt, 0); chk("t5_ep_cnt", ep_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (WL + 3) @(posedge clk);
    @(negedge clk);

    chk("left_issue", q_iss.size(), 0);
    chk("left_wen", q_wen.size(), 0);
    chk("left_done", q_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
